branch_predictor: RTL and testbench

//  Fetch-side producer of the branch-prediction signals that the hazard unit consumes.

---
 rtl/branch_predictor.sv | 130 +++++++++++++
 tb/tb_branch_predictor.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit saturating counters,
// prediction bit carried F->D->E, training on resolution in E, saturating performance counters.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      PCF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             FlushE,
    input  logic             BranchE,
    input  logic             BranchTakenE,
    input  logic [31:0]      BranchTargetE,
    input  logic [31:0]      PCE,
    output logic             PredictTakenF,
    output logic [31:0]      PredictedPCF,
    output logic             BranchPredictedE,
    output logic             MispredictE,
    output logic [31:0]      RecoverPCE,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] MispredictCount
);

    localparam int TAG_W = 32 - IDX_W - 2;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];

    logic             r_pred_d;
    logic             r_pred_e;
    logic [CNT_W-1:0] r_branch_count;
    logic [CNT_W-1:0] r_mispredict_count;

    logic [IDX_W-1:0] w_idx_f;
    logic [TAG_W-1:0] w_tag_f;
    logic             w_hit_f;
    logic [IDX_W-1:0] w_idx_e;
    logic [TAG_W-1:0] w_tag_e;
    logic             w_hit_e;
    logic             w_mispredict_e;
    logic             w_unused_pc_lsbs;

    assign w_unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

    // Fetch lookup reads the array before any same-edge training write lands.
    assign w_idx_f = PCF[IDX_W+1:2];
    assign w_tag_f = PCF[31:IDX_W+2];
    assign w_hit_f = !reset && r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);

    assign PredictTakenF = w_hit_f && r_ctr[w_idx_f][1];
    assign PredictedPCF  = PredictTakenF ? r_target[w_idx_f] : (PCF + 32'd4);

    assign w_idx_e = PCE[IDX_W+1:2];
    assign w_tag_e = PCE[31:IDX_W+2];
    assign w_hit_e = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);

    // Only the prediction bit travels to E: the full-PC tag and direct targets
    // guarantee a taken prediction already carried the correct target.
    assign w_mispredict_e   = BranchE && (BranchTakenE ^ r_pred_e);
    assign BranchPredictedE = r_pred_e;
    assign MispredictE      = w_mispredict_e;
    assign RecoverPCE       = BranchTakenE ? BranchTargetE : (PCE + 32'd4);

    assign BranchCount     = r_branch_count;
    assign MispredictCount = r_mispredict_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pred_d <= 1'b0;
        end else if (FlushD) begin
            r_pred_d <= 1'b0;
        end else if (!StallD) begin
            r_pred_d <= PredictTakenF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            r_pred_e <= 1'b0;
        end else begin
            r_pred_e <= r_pred_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b00;
            end
        end else if (BranchE) begin
            if (w_hit_e) begin
                if (BranchTakenE) begin
                    r_target[w_idx_e] <= BranchTargetE;
                    if (r_ctr[w_idx_e] != 2'b11) begin
                        r_ctr[w_idx_e] <= r_ctr[w_idx_e] + 2'b01;
                    end
                end else if (r_ctr[w_idx_e] != 2'b00) begin
                    r_ctr[w_idx_e] <= r_ctr[w_idx_e] - 2'b01;
                end
            end else if (BranchTakenE) begin
                // Allocation replaces whatever alias occupied the slot.
                r_valid[w_idx_e]  <= 1'b1;
                r_tag[w_idx_e]    <= w_tag_e;
                r_target[w_idx_e] <= BranchTargetE;
                r_ctr[w_idx_e]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (BranchE && (r_branch_count != {CNT_W{1'b1}})) begin
                r_branch_count <= r_branch_count + 1'b1;
            end
            if (w_mispredict_e && (r_mispredict_count != {CNT_W{1'b1}})) begin
                r_mispredict_count <= r_mispredict_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor; counters narrowed to 4 bits so saturation is reachable.
module tb_branch_predictor;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   PCF;
    logic          StallD, FlushD, FlushE;
    logic          BranchE, BranchTakenE;
    logic [31:0]   BranchTargetE, PCE;
    logic          PredictTakenF;
    logic [31:0]   PredictedPCF;
    logic          BranchPredictedE;
    logic          MispredictE;
    logic [31:0]   RecoverPCE;
    logic [CW-1:0] BranchCount, MispredictCount;

    int n_pass  = 0;
    int n_total = 0;

    branch_predictor #(.ENTRIES(16), .IDX_W(4), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .PCF(PCF),
        .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .BranchE(BranchE), .BranchTakenE(BranchTakenE),
        .BranchTargetE(BranchTargetE), .PCE(PCE),
        .PredictTakenF(PredictTakenF), .PredictedPCF(PredictedPCF),
        .BranchPredictedE(BranchPredictedE), .MispredictE(MispredictE),
        .RecoverPCE(RecoverPCE), .BranchCount(BranchCount),
        .MispredictCount(MispredictCount)
    );

    always #5 clk = ~clk;

    // Inputs change just after a falling edge; one step crosses exactly one rising edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        StallD = 0; FlushD = 0; FlushE = 0;
        BranchE = 0; BranchTakenE = 0; BranchTargetE = 32'h0; PCE = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1; idle_inputs(); PCF = 32'h200;
        step(); step();
        reset = 0;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        BranchE = 1; PCE = pc; BranchTakenE = taken; BranchTargetE = tgt;
        step();
        BranchE = 0; BranchTakenE = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs(); PCF = 32'h40;
        step();
        #1;
        n_total++; if (PredictTakenF !== 1'b0) $display("FAIL rst_pred_f got %0b exp 0", PredictTakenF); else n_pass++;
        n_total++; if (PredictedPCF !== 32'h44) $display("FAIL rst_pc_f got %h exp 00000044", PredictedPCF); else n_pass++;
        reset = 0;
        step();
        #1;
        n_total++; if (BranchPredictedE !== 1'b0) $display("FAIL rst_pred_e got %0b exp 0", BranchPredictedE); else n_pass++;
        n_total++; if (BranchCount !== 4'd0) $display("FAIL rst_bcount got %0d exp 0", BranchCount); else n_pass++;
        n_total++; if (MispredictCount !== 4'd0) $display("FAIL rst_mcount got %0d exp 0", MispredictCount); else n_pass++;
    endtask

    task automatic test_idle_no_train();
        do_reset();
        BranchE = 0; BranchTakenE = 1; PCE = 32'h40; BranchTargetE = 32'h100;
        #1;
        n_total++; if (MispredictE !== 1'b0) $display("FAIL idle_mispredict got %0b exp 0", MispredictE); else n_pass++;
        step();
        BranchTakenE = 0; PCF = 32'h40;
        #1;
        n_total++; if (PredictTakenF !== 1'b0) $display("FAIL idle_no_alloc got %0b exp 0", PredictTakenF); else n_pass++;
        n_total++; if (BranchCount !== 4'd0) $display("FAIL idle_bcount got %0d exp 0", BranchCount); else n_pass++;
    endtask

    task automatic test_allocate();
        do_reset();
        PCF = 32'h40;
        BranchE = 1; PCE = 32'h40; BranchTakenE = 1; BranchTargetE = 32'h100;
        #1;
        n_total++; if (MispredictE !== 1'b1) $display("FAIL alloc_mispredict got %0b exp 1", MispredictE); else n_pass++;
        n_total++; if (RecoverPCE !== 32'h100) $display("FAIL alloc_recover got %h exp 00000100", RecoverPCE); else n_pass++;
        step();
        BranchE = 0; BranchTakenE = 0;
        #1;
        n_total++; if (PredictTakenF !== 1'b1) $display("FAIL alloc_hit got %0b exp 1", PredictTakenF); else n_pass++;
        n_total++; if (PredictedPCF !== 32'h100) $display("FAIL alloc_target got %h exp 00000100", PredictedPCF); else n_pass++;
        n_total++; if (BranchCount !== 4'd1) $display("FAIL alloc_bcount got %0d exp 1", BranchCount); else n_pass++;
        n_total++; if (MispredictCount !== 4'd1) $display("FAIL alloc_mcount got %0d exp 1", MispredictCount); else n_pass++;
    endtask

    task automatic test_counter();
        do_reset();
        resolve(32'h40, 1, 32'h100);
        resolve(32'h40, 1, 32'h100);
        resolve(32'h40, 1, 32'h100);
        BranchE = 1; PCE = 32'h40; BranchTakenE = 0;
        #1;
        n_total++; if (RecoverPCE !== 32'h44) $display("FAIL ctr_recover_nt got %h exp 00000044", RecoverPCE); else n_pass++;
        step();
        BranchE = 0; PCF = 32'h40;
        #1;
        n_total++; if (PredictTakenF !== 1'b1) $display("FAIL ctr_10_pred got %0b exp 1", PredictTakenF); else n_pass++;
        PCF = 32'h200;
        resolve(32'h40, 0, 32'h0);
        PCF = 32'h40;
        #1;
        n_total++; if (PredictTakenF !== 1'b0) $display("FAIL ctr_01_pred got %0b exp 0", PredictTakenF); else n_pass++;
        n_total++; if (PredictedPCF !== 32'h44) $display("FAIL ctr_01_pc got %h exp 00000044", PredictedPCF); else n_pass++;
        PCF = 32'h200;
        resolve(32'h40, 0, 32'h0);
        resolve(32'h40, 0, 32'h0);
        resolve(32'h40, 1, 32'h100);
        PCF = 32'h40;
        #1;
        n_total++; if (PredictTakenF !== 1'b1 && PredictTakenF !== 1'b0) $display("FAIL ctr_x got %b", PredictTakenF); else n_pass++;
        n_total++; if (PredictTakenF !== 1'b0) $display("FAIL ctr_floor_pred got %0b exp 0", PredictTakenF); else n_pass++;
        n_total++; if (BranchCount !== 4'd8) $display("FAIL ctr_bcount got %0d exp 8", BranchCount); else n_pass++;
        n_total++; if (MispredictCount !== 4'd4) $display("FAIL ctr_mcount got %0d exp 4", MispredictCount); else n_pass++;
        PCF = 32'h200;
    endtask

    task automatic test_pipeline();
        do_reset();
        resolve(32'h40, 1, 32'h100);
        PCF = 32'h40; step();
        PCF = 32'h200; FlushE = 1; step();
        FlushE = 0;
        #1;
        n_total++; if (BranchPredictedE !== 1'b0) $display("FAIL flush_e_bubble got %0b exp 0", BranchPredictedE); else n_pass++;
        PCF = 32'h40; step();
        PCF = 32'h200; StallD = 1; FlushE = 1; step();
        #1;
        n_total++; if (BranchPredictedE !== 1'b0) $display("FAIL stall_c1 got %0b exp 0", BranchPredictedE); else n_pass++;
        step();
        StallD = 0; FlushE = 0; step();
        #1;
        n_total++; if (BranchPredictedE !== 1'b1) $display("FAIL stall_hold got %0b exp 1", BranchPredictedE); else n_pass++;
        BranchE = 1; PCE = 32'h40; BranchTakenE = 1; BranchTargetE = 32'h100;
        #1;
        n_total++; if (MispredictE !== 1'b0) $display("FAIL pred_correct got %0b exp 0", MispredictE); else n_pass++;
        step();
        BranchE = 0; BranchTakenE = 0;
        #1;
        n_total++; if (MispredictCount !== 4'd1) $display("FAIL pipe_mcount1 got %0d exp 1", MispredictCount); else n_pass++;
        PCF = 32'h40; step();
        PCF = 32'h200; step();
        BranchE = 1; PCE = 32'h40; BranchTakenE = 0;
        #1;
        n_total++; if (MispredictE !== 1'b1) $display("FAIL pred_wrong got %0b exp 1", MispredictE); else n_pass++;
        step();
        BranchE = 0;
        #1;
        n_total++; if (MispredictCount !== 4'd2) $display("FAIL pipe_mcount2 got %0d exp 2", MispredictCount); else n_pass++;
        n_total++; if (BranchCount !== 4'd3) $display("FAIL pipe_bcount got %0d exp 3", BranchCount); else n_pass++;
        PCF = 32'h40; step();
        StallD = 1; FlushD = 1; step();
        StallD = 0; FlushD = 0; PCF = 32'h200; step();
        #1;
        n_total++; if (BranchPredictedE !== 1'b0) $display("FAIL flush_d_priority got %0b exp 0", BranchPredictedE); else n_pass++;
    endtask

    task automatic test_same_cycle();
        do_reset();
        PCF = 32'h80;
        BranchE = 1; PCE = 32'h80; BranchTakenE = 1; BranchTargetE = 32'h300;
        #1;
        n_total++; if (PredictTakenF !== 1'b0) $display("FAIL same_cyc_old got %0b exp 0", PredictTakenF); else n_pass++;
        n_total++; if (PredictedPCF !== 32'h84) $display("FAIL same_cyc_pc got %h exp 00000084", PredictedPCF); else n_pass++;
        step();
        BranchE = 0; BranchTakenE = 0;
        #1;
        n_total++; if (PredictTakenF !== 1'b1) $display("FAIL same_cyc_new got %0b exp 1", PredictTakenF); else n_pass++;
        n_total++; if (PredictedPCF !== 32'h300) $display("FAIL same_cyc_tgt got %h exp 00000300", PredictedPCF); else n_pass++;
        PCF = 32'h200;
    endtask

    task automatic test_alias();
        do_reset();
        resolve(32'h40, 1, 32'h100);
        resolve(32'h80, 1, 32'h180);
        PCF = 32'h40;
        #1;
        n_total++; if (PredictTakenF !== 1'b0) $display("FAIL alias_evicted got %0b exp 0", PredictTakenF); else n_pass++;
        n_total++; if (PredictedPCF !== 32'h44) $display("FAIL alias_evicted_pc got %h exp 00000044", PredictedPCF); else n_pass++;
        PCF = 32'h200;
        resolve(32'hC0, 0, 32'h0);
        PCF = 32'h80;
        #1;
        n_total++; if (PredictTakenF !== 1'b1) $display("FAIL alias_nt_nowrite got %0b exp 1", PredictTakenF); else n_pass++;
        n_total++; if (PredictedPCF !== 32'h180) $display("FAIL alias_tgt got %h exp 00000180", PredictedPCF); else n_pass++;
        PCF = 32'h200;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 7; i++) resolve(32'h300 + 32'(i * 64), 1, 32'h400);
        #1;
        n_total++; if (MispredictCount !== 4'd7) $display("FAIL sat_mid got %0d exp 7", MispredictCount); else n_pass++;
        for (int i = 0; i < 13; i++) resolve(32'h300, 1, 32'h400);
        #1;
        n_total++; if (BranchCount !== 4'hF) $display("FAIL sat_bcount got %0d exp 15", BranchCount); else n_pass++;
        n_total++; if (MispredictCount !== 4'hF) $display("FAIL sat_mcount got %0d exp 15", MispredictCount); else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        resolve(32'h40, 1, 32'h100);
        PCF = 32'h40; step();
        do_reset();
        PCF = 32'h40;
        #1;
        n_total++; if (PredictTakenF !== 1'b0) $display("FAIL rst_mid_btb got %0b exp 0", PredictTakenF); else n_pass++;
        n_total++; if (BranchPredictedE !== 1'b0) $display("FAIL rst_mid_pred_e got %0b exp 0", BranchPredictedE); else n_pass++;
        n_total++; if (BranchCount !== 4'd0) $display("FAIL rst_mid_bcount got %0d exp 0", BranchCount); else n_pass++;
    endtask

    initial begin
        reset = 1; idle_inputs(); PCF = 32'h40;
        step();
        test_reset();
        test_idle_no_train();
        test_allocate();
        test_counter();
        test_pipeline();
        test_same_cycle();
        test_alias();
        test_saturation();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
